// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_e;

  // Successor of idx in a ring of n slots.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] grant_o,
  output logic            found_o
);

  // Walk the ring starting at ptr_i; the first hit wins and later hits are ignored.
  always_comb begin
    logic [ID_W:0] idx;
    logic          hit;
    grant_o = '0;
    found_o = 1'b0;
    idx     = '0;
    hit     = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx     = {1'b0, ptr_i} + (ID_W + 1)'(i);
      idx     = (idx >= (ID_W + 1)'(N)) ? (idx - (ID_W + 1)'(N)) : idx;
      hit     = ~found_o & req_i[idx[ID_W-1:0]];
      grant_o = hit ? idx[ID_W-1:0] : grant_o;
      found_o = found_o | hit;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional bus locking is compiled in with `define UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int WIDTH         = DEFAULT_WIDTH,
  parameter  int START_TIMEOUT = 64,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_lock,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     tx_send,
  input  logic                     tx_active,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic                     timeout_err
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc_s;
  logic               timeout_err_q, timeout_err_d;
  logic [NUM_REQ-1:0] req_elig_s, req_ready_s;
  logic [ID_W-1:0]    pick_id_s;
  logic               pick_found_s, accept_s, rr_hold_s;
  logic [WIDTH-1:0]   req_bytes_s [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes_s[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  uart_rr_picker #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .req_i   (req_elig_s),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_id_s),
    .found_o (pick_found_s)
  );

  // A foreign or leftover frame on the line blocks new grants.
  assign accept_s  = (state_q == IDLE) & ~tx_active & pick_found_s;
  assign cnt_inc_s = cnt_q + CNT_W'(1);

`ifdef UART_ARB_LOCK_EN
  logic               locked_q, locked_d;
  logic [ID_W-1:0]    lock_owner_q, lock_owner_d;
  logic               hold_lock_s, take_lock_s;
  logic [NUM_REQ-1:0] owner_mask_s;

  // While the owner keeps its lock, only the owner is eligible and the pointer is frozen.
  always_comb begin
    owner_mask_s               = '0;
    owner_mask_s[lock_owner_q] = 1'b1;
    hold_lock_s                = locked_q & req_lock[lock_owner_q];
    req_elig_s                 = hold_lock_s ? (req_valid & owner_mask_s) : req_valid;
    rr_hold_s                  = hold_lock_s;
  end

  // rr_ptr already sits at owner+1 from the grant that took the lock, so release resumes there.
  always_comb begin
    take_lock_s = accept_s & req_lock[pick_id_s];
    if (state_q == IDLE) begin
      locked_d     = hold_lock_s | take_lock_s;
      lock_owner_d = take_lock_s ? pick_id_s : lock_owner_q;
    end else begin
      locked_d     = locked_q;
      lock_owner_d = lock_owner_q;
    end
  end

  // Lock registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      locked_q     <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = ^req_lock;
  assign req_elig_s    = req_valid;
  assign rr_hold_s     = 1'b0;
`endif

  // Next-state and handshake sequencing for the shared transmitter.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    req_ready_s   = '0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          req_ready_s[pick_id_s] = 1'b1;
          tx_data_d              = req_bytes_s[pick_id_s];
          grant_id_d             = pick_id_s;
          rr_ptr_d               = rr_hold_s ? rr_ptr_q
                                             : ID_W'(rr_next(32'(pick_id_s), NUM_REQ));
          state_d                = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (tx_active) begin
          state_d = WAIT_DONE;
        end else if (cnt_inc_s == CNT_W'(START_TIMEOUT - 1)) begin
          // The byte is dropped; the requester already saw its accept pulse.
          cnt_d         = cnt_inc_s;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      WAIT_DONE: begin
        state_d = tx_active ? WAIT_DONE : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign req_ready   = req_ready_s;
  assign tx_data     = tx_data_q;
  assign tx_send     = (state_q == SEND);
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural UART transmitter model.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int W     = 8;
  localparam int TO    = 64;
  localparam int FRAME = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = 4'b0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_lock = 4'b0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_active = 1'b0;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic        uart_mute = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sent_q[$];
  int         rdy_cnt[4];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[8];

  uart_tx_arbiter #(
    .NUM_REQ       (NR),
    .WIDTH         (W),
    .START_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_lock    (req_lock),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_send     (tx_send),
    .tx_active   (tx_active),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // UART model: tx_active rises 2 cycles after tx_send and stays high FRAME cycles.
  initial begin : uart_model
    int dly;
    int left;
    dly  = 0;
    left = 0;
    forever begin
      @(negedge clk);
      if (left > 0) begin
        left--;
        if (left == 0) tx_active = 1'b0;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          tx_active = 1'b1;
          left      = FRAME;
        end
      end
      if (tx_send && !uart_mute) dly = 2;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while ((busy || tx_active) && t < 300);
    check({name, " idle bound"}, 32'(t < 300), 32'd1);
  endtask

  // Hold several requesters valid at once; requester i's k-th byte is 0x10+i+16*k.
  task automatic burst(input int n0, input int n1, input int n2, input int n3,
                       input logic [3:0] lock_mask);
    int         left[4];
    int         k[4];
    int         total;
    int         t;
    logic [3:0] hit;
    left  = '{n0, n1, n2, n3};
    k     = '{0, 0, 0, 0};
    total = n0 + n1 + n2 + n3;
    sent_q.delete();
    rdy_cnt = '{0, 0, 0, 0};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_valid[i]      = (left[i] > 0);
      req_lock[i]       = lock_mask[i] && (left[i] > 0);
      req_data[i*8 +: 8] = 8'h10 + 8'(i);
    end
    t = 0;
    while ((sent_q.size() < total || busy) && t < 1000) begin
      #1;
      hit = req_ready;
      if (tx_send) sent_q.push_back(tx_data);
      if (hit != 4'b0) check("burst ready one-hot", 32'($onehot(hit)), 32'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (hit[i]) begin
          rdy_cnt[i]++;
          k[i]++;
          left[i]--;
          req_data[i*8 +: 8] = 8'h10 + 8'(i) + 8'(16 * k[i]);
          if (left[i] <= 0) begin
            req_valid[i] = 1'b0;
            req_lock[i]  = 1'b0;
          end
        end
      end
      @(negedge clk);
      t++;
    end
    check("burst bound", 32'(t < 1000), 32'd1);
  endtask

  initial begin : main
    int         t;
    logic [3:0] exp_rdy;
    logic [7:0] exp_seq[4];

    vecs[0] = '{4'b0010, 32'h0000_A500, 2'd1, 8'hA5};
    vecs[1] = '{4'b1111, 32'h1312_1110, 2'd2, 8'h12};
    vecs[2] = '{4'b1001, 32'h1312_1110, 2'd3, 8'h13};
    vecs[3] = '{4'b1001, 32'h1312_1110, 2'd0, 8'h10};
    vecs[4] = '{4'b0001, 32'h5A5A_5A3C, 2'd0, 8'h3C};
    vecs[5] = '{4'b1100, 32'h4433_2211, 2'd2, 8'h33};
    vecs[6] = '{4'b0011, 32'h4433_2211, 2'd0, 8'h11};
    vecs[7] = '{4'b1000, 32'hC0FF_EE77, 2'd3, 8'hC0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", 32'(req_ready), 32'h0);
    check("rst tx_data", 32'(tx_data), 32'h0);
    check("rst tx_send", 32'(tx_send), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst grant_id", 32'(grant_id), 32'h0);
    check("rst timeout_err", 32'(timeout_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single transactions from the vector table
    for (int v = 0; v < 8; v++) begin
      wait_idle($sformatf("v%0d", v));
      @(negedge clk);
      req_valid = vecs[v].valid;
      req_data  = vecs[v].data;
      #1;
      exp_rdy = 4'b0001 << vecs[v].exp_id;
      check($sformatf("v%0d req_ready", v), 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      req_valid = 4'b0;
      @(negedge clk);
      check($sformatf("v%0d tx_send", v), 32'(tx_send), 32'd1);
      check($sformatf("v%0d tx_data", v), 32'(tx_data), 32'(vecs[v].exp_byte));
      check($sformatf("v%0d grant_id", v), 32'(grant_id), 32'(vecs[v].exp_id));
      check($sformatf("v%0d busy", v), 32'(busy), 32'd1);
      check($sformatf("v%0d ready after accept", v), 32'(req_ready), 32'h0);
      @(negedge clk);
      check($sformatf("v%0d tx_send single", v), 32'(tx_send), 32'd0);
      t = 0;
      while (!tx_active && t < 20) begin
        @(posedge clk);
        #1;
        t++;
      end
      check($sformatf("v%0d busy in frame", v), 32'(busy && tx_active), 32'd1);
    end

    // All four valid together: strict rotation from pointer 0
    wait_idle("burst4");
    burst(1, 1, 1, 1, 4'b0000);
    exp_seq = '{8'h10, 8'h11, 8'h12, 8'h13};
    check("burst4 count", 32'(sent_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < sent_q.size()) check($sformatf("burst4 byte%0d", i), 32'(sent_q[i]), 32'(exp_seq[i]));
      check($sformatf("burst4 ready count %0d", i), 32'(rdy_cnt[i]), 32'd1);
    end

    // Start timeout: UART never responds
    uart_mute = 1'b1;
    wait_idle("timeout");
    @(negedge clk);
    req_valid = 4'b0100;
    req_data  = 32'h0077_0000;
    #1;
    check("to req_ready", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1;
    req_valid = 4'b0;
    @(negedge clk);
    check("to tx_send", 32'(tx_send), 32'd1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!timeout_err && t < 200);
    check("to latency", 32'(t), 32'd64);
    check("to busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("to pulse width", 32'(timeout_err), 32'd0);
    uart_mute = 1'b0;
    @(negedge clk);
    req_valid = 4'b0001;
    req_data  = 32'h0000_00E1;
    #1;
    check("after-to req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 4'b0;
    @(negedge clk);
    check("after-to tx_data", 32'(tx_data), 32'hE1);
    check("after-to tx_send", 32'(tx_send), 32'd1);
    wait_idle("after-to");

    // Reset in WAIT_DONE; pointer back to 0 afterwards
    @(negedge clk);
    req_valid = 4'b0100;
    req_data  = 32'h0055_0000;
    #1;
    check("rw req_ready", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1;
    req_valid = 4'b0;
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!tx_active && t < 50);
    check("rw frame start bound", 32'(t < 50), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rw busy", 32'(busy), 32'd0);
    check("rw tx_send", 32'(tx_send), 32'd0);
    check("rw tx_data", 32'(tx_data), 32'd0);
    check("rw grant_id", 32'(grant_id), 32'd0);
    check("rw timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b1001;
    req_data  = 32'h9900_0088;
    #1;
    check("rw withheld while active", 32'(req_ready), 32'h0);
    t = 0;
    while (req_ready == 4'b0 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("rw first winner", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 4'b0;
    @(negedge clk);
    check("rw tx_data", 32'(tx_data), 32'h88);
    wait_idle("rw");

`ifdef UART_ARB_LOCK_EN
    // Requester 2 locks the bus for three bytes while requester 0 waits
    burst(1, 0, 3, 0, 4'b0100);
    exp_seq = '{8'h12, 8'h22, 8'h32, 8'h10};
    check("lock count", 32'(sent_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < sent_q.size()) check($sformatf("lock byte%0d", i), 32'(sent_q[i]), 32'(exp_seq[i]));
    end
    check("lock ready count 2", 32'(rdy_cnt[2]), 32'd3);
    check("lock ready count 0", 32'(rdy_cnt[0]), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
